// File: rtl/connect4_engine.sv
// Connect-4 game engine: accepts column drops over valid/ready, keeps the
// board and column heights, and runs a 4-cycle win check after each move.
module connect4_engine #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int CW      = $clog2(COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             new_game,
  input  logic                             drop_valid,
  input  logic [CW-1:0]                    drop_col,
  output logic                             drop_ready,
  output logic                             drop_ack,
  output logic                             drop_err,
  output logic                             player,
  output logic [1:0]                       game_status,
  output logic [ROWS*COLS-1:0]             board_occ,
  output logic [ROWS*COLS-1:0]             board_p2,
  output logic [$clog2(ROWS*COLS+1)-1:0]   move_count
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned HW    = $clog2(ROWS + 1);
  localparam int unsigned IW    = $clog2(NCELL);
  localparam int unsigned MW    = $clog2(NCELL + 1);
  localparam int unsigned NCP   = 1 << CW;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t          state;
  logic [HW-1:0]   h [NCP];
  logic [HW-1:0]   lr;
  logic [CW-1:0]   lc;
  logic [1:0]      dir;

  logic [HW-1:0]   h_sel;
  logic            legal;
  logic [IW-1:0]   place_idx;

  int              dr;
  int              dc;
  int              cnt_pos;
  int              cnt_neg;
  logic            run_pos;
  logic            run_neg;
  logic            win_c;

  // True when (r,c) is on the board and holds a piece of side pl.
  function automatic logic cell_match(input int r, input int c,
                                      input logic [NCELL-1:0] occ,
                                      input logic [NCELL-1:0] p2,
                                      input logic pl);
    logic [IW-1:0] idx;
    idx        = '0;
    cell_match = 1'b0;
    if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      idx        = IW'(r * COLS + c);
      cell_match = occ[idx] && (p2[idx] == pl);
    end
  endfunction

  // Decode the requested column: landing height, legality and cell index.
  always_comb begin
    h_sel     = h[drop_col];
    legal     = (int'(drop_col) < COLS) && (int'(h_sel) < ROWS);
    place_idx = IW'(int'(h_sel) * COLS + int'(drop_col));
  end

  // Count matching pieces on both sides of the last move along direction dir.
  always_comb begin
    dr = 0;
    dc = 1;
    case (dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    cnt_pos = 0;
    cnt_neg = 0;
    run_pos = 1'b1;
    run_neg = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      if (run_pos && cell_match(int'(lr) + k * dr, int'(lc) + k * dc,
                                board_occ, board_p2, player))
        cnt_pos = cnt_pos + 1;
      else
        run_pos = 1'b0;
      if (run_neg && cell_match(int'(lr) - k * dr, int'(lc) - k * dc,
                                board_occ, board_p2, player))
        cnt_neg = cnt_neg + 1;
      else
        run_neg = 1'b0;
    end
    win_c = (1 + cnt_pos + cnt_neg) >= WIN_LEN;
  end

  // Game FSM with board, heights and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state       <= S_IDLE;
      drop_ready  <= 1'b1;
      drop_ack    <= 1'b0;
      drop_err    <= 1'b0;
      player      <= 1'b0;
      game_status <= 2'b00;
      board_occ   <= '0;
      board_p2    <= '0;
      move_count  <= '0;
      lr          <= '0;
      lc          <= '0;
      dir         <= 2'd0;
      for (int i = 0; i < NCP; i++) h[i] <= '0;
    end else begin
      drop_ack <= 1'b0;
      drop_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (drop_valid) begin
            if (legal) begin
              board_occ[place_idx] <= 1'b1;
              board_p2[place_idx]  <= player;
              h[drop_col]          <= h_sel + HW'(1);
              move_count           <= move_count + MW'(1);
              lr                   <= h_sel;
              lc                   <= drop_col;
              dir                  <= 2'd0;
              drop_ack             <= 1'b1;
              drop_ready           <= 1'b0;
              state                <= S_CHECK;
            end else begin
              drop_err <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (win_c) begin
            game_status <= {player, ~player};
            state       <= S_DONE;
          end else if (dir == 2'd3) begin
            if (move_count == MW'(NCELL)) begin
              game_status <= 2'b11;
              state       <= S_DONE;
            end else begin
              player     <= ~player;
              drop_ready <= 1'b1;
              state      <= S_IDLE;
            end
          end else begin
            dir <= dir + 2'd1;
          end
        end
        S_DONE: begin
        end
        default: begin
          state      <= S_IDLE;
          drop_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_engine.sv
// Scoreboard bench for connect4_engine: a board-array reference model predicts
// each drop's response; a monitor checks acks/errs and the win-check outcome.
module tb_connect4_engine;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int WL   = 4;
  localparam int NC   = ROWS * COLS;

  logic          clk;
  logic          reset;
  logic          new_game;
  logic          drop_valid;
  logic [2:0]    drop_col;
  logic          drop_ready;
  logic          drop_ack;
  logic          drop_err;
  logic          player;
  logic [1:0]    game_status;
  logic [NC-1:0] board_occ;
  logic [NC-1:0] board_p2;
  logic [5:0]    move_count;

  connect4_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WL)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
    .drop_ack(drop_ack), .drop_err(drop_err), .player(player),
    .game_status(game_status), .board_occ(board_occ), .board_p2(board_p2),
    .move_count(move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_ack;
    bit            abort;
    int            mc;
    logic [NC-1:0] occ;
    logic [NC-1:0] p2;
    int            plyr_during;
    int            status_after;
    int            plyr_after;
    int            lat;
    int            ready_after;
  } exp_t;

  exp_t q[$];
  bit   mon_busy;
  int   n_checks;
  int   n_err;

  // Reference model: board of 0 (empty), 1 (P1), 2 (P2).
  int brd [ROWS][COLS];
  int ht  [COLS];
  int m_player;
  int m_status;
  int m_mc;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) brd[r][c] = 0;
    for (int c = 0; c < COLS; c++) ht[c] = 0;
    m_player = 0;
    m_status = 0;
    m_mc     = 0;
  endfunction

  function automatic logic [NC-1:0] model_occ();
    logic [NC-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[r*COLS+c] = (brd[r][c] != 0);
    return v;
  endfunction

  function automatic logic [NC-1:0] model_p2();
    logic [NC-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[r*COLS+c] = (brd[r][c] == 2);
    return v;
  endfunction

  // First direction (0..3) in which some WL-long window through (r,c) is all p; -1 if none.
  function automatic int win_dir(input int r, input int c, input int p);
    int dr, dc, rr, cc;
    bit ok;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dr = 0; dc = 1;  end
        1:       begin dr = 1; dc = 0;  end
        2:       begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      for (int s = 0; s < WL; s++) begin
        ok = 1;
        for (int k = 0; k < WL; k++) begin
          rr = r + (k - s) * dr;
          cc = c + (k - s) * dc;
          if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
          else if (brd[rr][cc] != p) ok = 0;
        end
        if (ok) return d;
      end
    end
    return -1;
  endfunction

  function automatic exp_t model_drop(input int col, input bit abort);
    exp_t e;
    int   r, d;
    e.abort       = abort;
    e.plyr_during = m_player;
    if (col >= COLS || ht[col] >= ROWS) begin
      e.is_ack = 0;
    end else begin
      e.is_ack = 1;
      r = ht[col];
      brd[r][col] = m_player + 1;
      ht[col]++;
      m_mc++;
      d = win_dir(r, col, m_player + 1);
      if (d >= 0) begin
        m_status = m_player + 1;
        e.lat = d + 1;
        e.ready_after = 0;
      end else if (m_mc == NC) begin
        m_status = 3;
        e.lat = 4;
        e.ready_after = 0;
      end else begin
        m_player ^= 1;
        e.lat = 4;
        e.ready_after = 1;
      end
    end
    e.mc           = m_mc;
    e.occ          = model_occ();
    e.p2           = model_p2();
    e.status_after = m_status;
    e.plyr_after   = m_player;
    return e;
  endfunction

  task automatic check_reset();
    chk("rst_ready",  drop_ready,  1);
    chk("rst_ack",    drop_ack,    0);
    chk("rst_err",    drop_err,    0);
    chk("rst_player", player,      0);
    chk("rst_status", game_status, 0);
    chk("rst_occ",    board_occ,   0);
    chk("rst_p2",     board_p2,    0);
    chk("rst_mc",     move_count,  0);
  endtask

  // Issue one drop; a finished game expects the request to be ignored.
  task automatic do_drop(input int col, input bit abort);
    exp_t e;
    int   i;
    @(negedge clk);
    if (m_status != 0) begin
      drop_valid = 1'b1;
      drop_col   = 3'(col);
      repeat (2) @(posedge clk);
      #1 drop_valid = 1'b0;
      @(negedge clk);
      chk("done_mc",     move_count,  m_mc);
      chk("done_ready",  drop_ready,  0);
      chk("done_status", game_status, m_status);
      return;
    end
    i = 0;
    while (!drop_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (i >= 50) chk("ready_timeout", 0, 1);
    e = model_drop(col, abort);
    q.push_back(e);
    drop_valid = 1'b1;
    drop_col   = 3'(col);
    @(posedge clk);
    #1 drop_valid = 1'b0;
  endtask

  task automatic settle();
    int i = 0;
    while ((q.size() != 0 || mon_busy) && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (i >= 50) chk("settle_timeout", 0, 1);
  endtask

  task automatic pulse_clear(input bit use_ng);
    settle();
    @(negedge clk);
    if (use_ng) new_game = 1'b1;
    else        reset    = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset();
  endtask

  // Monitor: pop the oldest expectation on every ack/err and follow the win check.
  initial begin
    exp_t e;
    int   lat;
    mon_busy = 0;
    forever begin
      @(negedge clk);
      if (drop_ack || drop_err) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: ack=%0b err=%0b expected neither", drop_ack, drop_err);
        end else begin
          mon_busy = 1;
          e = q.pop_front();
          chk("resp_ack",    drop_ack,             e.is_ack);
          chk("resp_err",    drop_err,             !e.is_ack);
          chk("resp_mc",     move_count,           e.mc);
          chk("resp_occ",    board_occ,            e.occ);
          chk("resp_p2",     board_p2 & board_occ, e.p2);
          chk("resp_player", player,               e.plyr_during);
          chk("resp_ready",  drop_ready,           !e.is_ack);
          if (e.is_ack && !e.abort) begin
            lat = 0;
            while (lat < 10) begin
              @(negedge clk);
              lat++;
              if (game_status != 2'b00 || drop_ready) break;
            end
            chk("chk_latency", lat,         e.lat);
            chk("chk_status",  game_status, e.status_after);
            chk("chk_player",  player,      e.plyr_after);
            chk("chk_ready",   drop_ready,  e.ready_after);
          end
          mon_busy = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vert[7]  = '{0, 1, 0, 1, 0, 1, 0};
  int horiz[8] = '{0, 1, 0, 2, 0, 3, 6, 4};
  int diag[11] = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
  int draw_seq[$];

  initial begin
    n_checks   = 0;
    n_err      = 0;
    reset      = 1'b1;
    new_game   = 1'b0;
    drop_valid = 1'b0;
    drop_col   = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset();

    // Vertical P1 win, ignored drop in DONE, new_game from DONE.
    foreach (vert[i]) do_drop(vert[i], 0);
    settle();
    do_drop(5, 0);
    pulse_clear(1);

    // Horizontal P2 win, then reset out of DONE.
    foreach (horiz[i]) do_drop(horiz[i], 0);
    settle();
    do_drop(5, 0);
    pulse_clear(0);

    // Diagonal win ending at (3,3), then its mirror image (anti-diagonal).
    foreach (diag[i]) do_drop(diag[i], 0);
    pulse_clear(1);
    foreach (diag[i]) do_drop(diag[i] == 6 ? 6 : 3 - diag[i], 0);
    pulse_clear(1);

    // Full column and out-of-range column are rejected.
    repeat (6) do_drop(2, 0);
    do_drop(2, 0);
    do_drop(7, 0);
    pulse_clear(1);

    // 42-move fill with no four-in-a-row ends in a draw.
    for (int p = 0; p < 3; p++) begin
      int a, b;
      a = (p == 0) ? 0 : (p == 1) ? 1 : 4;
      b = a + 2;
      repeat (3) begin
        draw_seq.push_back(a);
        draw_seq.push_back(b);
        draw_seq.push_back(b);
        draw_seq.push_back(a);
      end
    end
    repeat (6) draw_seq.push_back(5);
    foreach (draw_seq[i]) do_drop(draw_seq[i], 0);
    settle();
    do_drop(0, 0);
    pulse_clear(1);

    // Reset lands mid-check (edge T+2).
    do_drop(1, 0);
    do_drop(3, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset();

    // A drop presented together with reset is not taken.
    @(negedge clk);
    reset      = 1'b1;
    drop_valid = 1'b1;
    drop_col   = 3'd4;
    @(posedge clk);
    #1 reset = 1'b0;
    drop_valid = 1'b0;
    @(negedge clk);
    check_reset();

    // Random games, including illegal columns and full-column drops.
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 60; i++) begin
        if (m_status != 0) break;
        do_drop(int'($urandom_range(0, 7)), 0);
      end
      settle();
      if (m_status != 0) do_drop(int'($urandom_range(0, 6)), 0);
      pulse_clear(g[0]);
    end

    settle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
